// File: rtl/ok_alu_sequencer.sv
// Command sequencer sharing one 32-bit add/subtract datapath between ADD, SUB,
// shift-and-add MUL, ACC and CLR, reporting through result/status/done_pulse.
module ok_alu_sequencer #(
  parameter int CNT_W        = 16,
  parameter bit ACC_SATURATE = 1'b0
) (
  input  logic        okClk,
  input  logic        rst_n,
  input  logic        cmd_trig,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [31:0] result,
  output logic [31:0] status,
  output logic        done_pulse
);

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_ACC = 3'd4;
  localparam logic [2:0] OP_CLR = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MULT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [31:0]        mcand_q, mcand_d, mplier_q, mplier_d, part_q, part_d;
  logic [4:0]         iter_q, iter_d;
  logic               spill_q, spill_d, ovf_pend_q, ovf_pend_d;
  logic [31:0]        result_q, result_d;
  logic               done_q, done_d, err_q, err_d, ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_pulse_q, done_pulse_d;

  logic [31:0]        add_x, add_y;
  logic               add_sub;
  logic [32:0]        sum;

  // Shared adder: in MULT it accumulates partial products, otherwise it serves the latched op.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_sub = 1'b0;
    if (state_q == S_MULT) begin
      add_x = part_q;
      add_y = mcand_q;
    end else begin
      case (op_q)
        OP_SUB:  begin add_x = a_q;      add_y = b_q; add_sub = 1'b1; end
        OP_ACC:  begin add_x = result_q; add_y = a_q; end
        default: begin add_x = a_q;      add_y = b_q; end
      endcase
    end
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y ^ {32{add_sub}}} + {32'd0, add_sub};

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    part_d       = part_q;
    iter_d       = iter_q;
    spill_d      = spill_q;
    ovf_pend_d   = ovf_pend_q;
    result_d     = result_q;
    done_d       = done_q;
    err_d        = err_q;
    ovf_d        = ovf_q;
    cnt_d        = cnt_q;
    done_pulse_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_trig) begin
          if (cmd_op <= OP_CLR) begin
            op_d    = cmd_op;
            a_d     = cmd_a;
            b_d     = cmd_b;
            done_d  = 1'b0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = S_EXEC;
          end else begin
            err_d        = 1'b1;
            done_pulse_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (cmd_trig) err_d = 1'b1;
        state_d = S_DONE;
        case (op_q)
          OP_ADD: begin part_d = sum[31:0]; ovf_pend_d = sum[32]; end
          // Carry out of A + ~B + 1 is the inverse of borrow.
          OP_SUB: begin part_d = sum[31:0]; ovf_pend_d = ~sum[32]; end
          OP_ACC: begin
            part_d     = (sum[32] && ACC_SATURATE) ? 32'hFFFF_FFFF : sum[31:0];
            ovf_pend_d = sum[32];
          end
          OP_CLR: begin part_d = '0; ovf_pend_d = 1'b0; end
          OP_MUL: begin
            mcand_d    = a_q;
            mplier_d   = b_q;
            part_d     = '0;
            iter_d     = '0;
            spill_d    = 1'b0;
            ovf_pend_d = 1'b0;
            state_d    = S_MULT;
          end
          default: begin part_d = result_q; ovf_pend_d = 1'b0; end
        endcase
      end
      S_MULT: begin
        if (cmd_trig) err_d = 1'b1;
        // A set multiplier bit while multiplicand bits have spilled past bit 31 means product >= 2^32.
        if (mplier_q[0]) begin
          part_d     = sum[31:0];
          ovf_pend_d = ovf_pend_q | sum[32] | spill_q;
        end
        mcand_d  = mcand_q << 1;
        spill_d  = spill_q | mcand_q[31];
        mplier_d = mplier_q >> 1;
        iter_d   = iter_q + 5'd1;
        if (iter_q == 5'd31) state_d = S_DONE;
      end
      S_DONE: begin
        if (cmd_trig) err_d = 1'b1;
        result_d     = part_q;
        ovf_d        = ovf_pend_q;
        done_d       = 1'b1;
        cnt_d        = cnt_q + CNT_W'(1);
        done_pulse_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge okClk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      part_q       <= '0;
      iter_q       <= '0;
      spill_q      <= 1'b0;
      ovf_pend_q   <= 1'b0;
      result_q     <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      cnt_q        <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      part_q       <= part_d;
      iter_q       <= iter_d;
      spill_q      <= spill_d;
      ovf_pend_q   <= ovf_pend_d;
      result_q     <= result_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      cnt_q        <= cnt_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  always_comb begin
    status              = '0;
    status[0]           = (state_q != S_IDLE);
    status[1]           = done_q;
    status[2]           = err_q;
    status[3]           = ovf_q;
    status[16 +: CNT_W] = cnt_q;
  end

  assign result     = result_q;
  assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_ok_alu_sequencer.sv
// Bench for ok_alu_sequencer: a wrapping and a saturating instance receive identical
// commands; results are predicted from plain 64-bit arithmetic in a reference model.
module tb_ok_alu_sequencer;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_ACC = 3'd4;
  localparam logic [2:0] OP_CLR = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_trig;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [31:0] result, status, result_s, status_s;
  logic        done_pulse, done_pulse_s;

  always #5 clk = ~clk;

  ok_alu_sequencer dut (
    .okClk(clk), .rst_n(rst_n), .cmd_trig(cmd_trig), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .result(result), .status(status),
    .done_pulse(done_pulse)
  );

  ok_alu_sequencer #(.CNT_W(16), .ACC_SATURATE(1'b1)) dut_s (
    .okClk(clk), .rst_n(rst_n), .cmd_trig(cmd_trig), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .result(result_s), .status(status_s),
    .done_pulse(done_pulse_s)
  );

  // Reference model state and scoreboard
  logic [31:0] m_res, m_res_s;
  logic [15:0] m_cnt;
  logic        m_done, m_err, m_ovf, m_ovf_s;
  logic [31:0] exp_q[$];
  logic [31:0] exp_s_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input logic ovf);
    return {m_cnt, 12'b0, ovf, m_err, m_done, 1'b0};
  endfunction

  // Returns {ovf, result} for one command given the instance's current result.
  function automatic logic [32:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] cur,
                                         input logic sat);
    logic [32:0] s;
    logic [63:0] p;
    case (op)
      OP_ADD: s = 33'(a) + 33'(b);
      OP_SUB: s = {a < b, a - b};
      OP_MUL: begin p = 64'(a) * 64'(b); s = {|p[63:32], p[31:0]}; end
      OP_ACC: begin
        s = 33'(cur) + 33'(a);
        if (sat && s[32]) s[31:0] = 32'hFFFF_FFFF;
      end
      OP_CLR: s = '0;
      default: s = {1'b0, cur};
    endcase
    return s;
  endfunction

  task automatic model_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r, rs;
    r  = ref_op(op, a, b, m_res, 1'b0);
    rs = ref_op(op, a, b, m_res_s, 1'b1);
    m_res   = r[31:0];
    m_ovf   = r[32];
    m_res_s = rs[31:0];
    m_ovf_s = rs[32];
    m_done  = 1'b1;
    m_err   = 1'b0;
    m_cnt   = m_cnt + 16'd1;
    exp_q.push_back(m_res);
    exp_s_q.push_back(m_res_s);
  endtask

  task automatic model_reset();
    m_res = '0; m_res_s = '0; m_cnt = '0;
    m_done = 1'b0; m_err = 1'b0; m_ovf = 1'b0; m_ovf_s = 1'b0;
    exp_q.delete();
    exp_s_q.delete();
  endtask

  // Driver: present a command with a one-cycle trigger, then scramble the wires.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_trig = 1'b1;
    @(posedge clk); #1;
    cmd_trig = 1'b0;
    cmd_a = $urandom; cmd_b = $urandom; cmd_op = 3'($urandom_range(0, 7));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_result"}, result, m_res);
    check({tag, "_status"}, status, exp_status(m_ovf));
    check({tag, "_result_s"}, result_s, m_res_s);
    check({tag, "_status_s"}, status_s, exp_status(m_ovf_s));
  endtask

  // Runs one legal command; poke>0 injects a stray ADD trigger sampled at that edge after launch.
  task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int poke);
    int lat;
    int want;
    want = (op == OP_MUL) ? 34 : 2;
    model_cmd(op, a, b);
    if (poke > 0) m_err = 1'b1;
    issue(op, a, b);
    check("launch_dp", 32'(done_pulse), 32'd0);
    check("launch_busy", 32'(status[0]), 32'd1);
    lat = 0;
    do begin
      if (lat + 1 == poke) begin
        @(negedge clk);
        cmd_trig = 1'b1; cmd_op = OP_ADD; cmd_a = $urandom; cmd_b = $urandom;
      end
      @(posedge clk); #1;
      cmd_trig = 1'b0;
      lat++;
      if (!done_pulse && lat < want) check("busy_run", 32'(status[0]), 32'd1);
    end while (!done_pulse && lat < 60);
    check("latency", 32'(lat), 32'(want));
    check("dp_s", 32'(done_pulse_s), 32'd1);
    check("res_sb", result, exp_q.pop_front());
    check("res_s_sb", result_s, exp_s_q.pop_front());
    check("status_done", status, exp_status(m_ovf));
    check("status_s_done", status_s, exp_status(m_ovf_s));
  endtask

  task automatic run_illegal(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    m_err = 1'b1;
    issue(op, a, b);
    check("ill_dp", 32'(done_pulse), 32'd1);
    check("ill_dp_s", 32'(done_pulse_s), 32'd1);
    check_idle_outputs("ill");
    @(posedge clk); #1;
    check("ill_dp_clear", 32'(done_pulse), 32'd0);
    check_idle_outputs("ill_after");
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h0;
      2: return 32'($urandom_range(0, 255));
      3: return 32'h8000_0000 | 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] op;
    int         poke;
    rst_n = 1'b0; cmd_trig = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_dp", 32'(done_pulse), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd(OP_ADD, 32'd5, 32'd7, 0);
    check("add_count_one", 32'(status[31:16]), 32'd1);
    run_cmd(OP_SUB, 32'd3, 32'd5, 0);
    run_cmd(OP_ADD, 32'hFFFF_FFFF, 32'd1, 0);
    run_cmd(OP_MUL, 32'h0001_0000, 32'h0001_0000, 0);
    run_cmd(OP_MUL, 32'd1234, 32'd5678, 0);
    check("mul_small", result, 32'd7006652);
    run_cmd(OP_NOP, 32'd9, 32'd9, 0);

    run_cmd(OP_CLR, 32'd0, 32'd0, 0);
    repeat (3) run_cmd(OP_ACC, 32'd10, 32'd0, 0);
    check("acc_thirty", result, 32'd30);
    run_cmd(OP_CLR, 32'd0, 32'd0, 0);
    run_cmd(OP_ACC, 32'hFFFF_FFF0, 32'd0, 0);
    run_cmd(OP_ACC, 32'h20, 32'd0, 0);
    check("acc_sat", result_s, 32'hFFFF_FFFF);

    run_cmd(OP_MUL, 32'd1234, 32'd5678, 10);
    run_cmd(OP_ADD, 32'd1, 32'd2, 0);
    run_cmd(OP_ADD, 32'd100, 32'd200, 2);
    run_illegal(3'd7, 32'd1, 32'd1);
    run_illegal(3'd6, 32'd2, 32'd3);

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op > OP_CLR) begin
        run_illegal(op, pick_operand(), pick_operand());
      end else begin
        poke = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (op == OP_MUL) ? 34 : 2) : 0;
        run_cmd(op, pick_operand(), pick_operand(), poke);
      end
    end

    // Reset during MULT iteration 20 aborts the multiply.
    run_cmd(OP_ADD, 32'd1, 32'd1, 0);
    issue(OP_MUL, 32'd1234, 32'd5678);
    repeat (21) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(status[0]), 32'd1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_idle_outputs("mid_reset");
    check("mid_reset_dp", 32'(done_pulse), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (14) begin
      @(posedge clk); #1;
      check("abort_no_dp", 32'(done_pulse), 32'd0);
    end
    check_idle_outputs("abort_idle");

    // Reset and trigger together: reset wins, nothing starts.
    @(negedge clk); rst_n = 1'b0; cmd_trig = 1'b1; cmd_op = OP_ADD;
    @(posedge clk); #1;
    cmd_trig = 1'b0;
    check_idle_outputs("rst_trig");
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_trig_dp", 32'(done_pulse), 32'd0);
    end
    check_idle_outputs("rst_trig_idle");

    run_cmd(OP_ADD, 32'd5, 32'd7, 0);
    check("post_reset_count", 32'(status[31:16]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ok_alu_sequencer.md
Name: ok_alu_sequencer

Overview:
- Command sequencer that shares one 32-bit add/subtract datapath among several host-issued operations: ADD, SUB, multi-cycle MUL, accumulate and clear.
- Sits between FrontPanel endpoints and the datapath.
  - Inputs come from Wire Ins: operands and opcode.
  - Starts on a TriggerIn pulse.
  - Reports results and status through Wire Outs, plus a TriggerOut done pulse.
- Everything runs in the okClk domain.

Parameters:
- CNT_W, 16, width of completed-command counter (1..16); occupies status[16 +: CNT_W], upper status bits 0.
- ACC_SATURATE, 0, 1: ACC clamps at 32'hFFFFFFFF on carry; 0: ACC wraps.

Ports:
- okClk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_trig  in  1  single-cycle start pulse (TriggerIn).
- cmd_op  in  3  opcode: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 ACC, 5 CLR, 6-7 illegal.
- cmd_a  in  32  operand A (Wire In).
- cmd_b  in  32  operand B (Wire In).
- result  out  32  result register (Wire Out).
- status  out  32  status word:
  - [0] busy
  - [1] done (sticky)
  - [2] err (sticky)
  - [3] ovf
  - [15:4] zero
  - [16 +: CNT_W] cmd_count
- done_pulse  out  1  one-cycle completion pulse (TriggerOut).

Behaviour:
- Reset (rst_n low at an edge): state IDLE; result, status, done_pulse, internal operand/partial registers all 0. Applies mid-operation: the operation is aborted, no done_pulse, counter not incremented.
- States: IDLE, EXEC, MULT, DONE.
- IDLE:
  - cmd_trig=1 with a legal op: latch cmd_op/cmd_a/cmd_b, clear done/err/ovf, go EXEC.
  - cmd_trig=1 with an illegal op: stay IDLE, set err, pulse done_pulse next cycle, do not count.
- EXEC:
  - Single-cycle ops perform the operation and go DONE.
  - MUL loads multiplicand=A, multiplier=B, partial=0, iter=0, and goes MULT.
- MULT: one iteration per cycle.
  - If multiplier[0], partial+=multiplicand through the shared adder.
  - multiplicand<<=1, multiplier>>=1.
  - Exactly 32 iterations, no early exit, then go DONE.
- DONE: write result, increment cmd_count (wraps at 2^CNT_W), set done, assert done_pulse for this cycle only, go IDLE.
- busy=1 in EXEC, MULT and DONE. busy falls in the cycle after done_pulse.
- Latency, counted in edges from the edge sampling cmd_trig to the edge setting done_pulse:
  - NOP/ADD/SUB/ACC/CLR: 2.
  - MUL: 34.
- Arithmetic (unsigned 32-bit, result = low 32 bits):
  - ADD: A+B; ovf=carry out.
  - SUB: A-B; ovf=borrow (A<B).
  - MUL: ovf=1 if any bit of the 64-bit product above bit 31 is set. Tracked by the adder carry plus multiplicand bits shifted past bit 31 while the multiplier bit is set.
  - ACC: result+A; ovf=carry; if ACC_SATURATE, result=32'hFFFFFFFF on carry.
  - CLR: result=0, ovf=0.
  - NOP: result unchanged.
- Operand stability: cmd_a/cmd_b/cmd_op changes after the latch edge have no effect on the running op.
- Trigger while busy (including the DONE cycle):
  - Ignored; the running op continues unaffected.
  - err set; it stays set through completion because the completion does not clear it.
- Trigger accepted again from IDLE, including the cycle immediately after done_pulse.
- Simultaneous rst_n low and cmd_trig: reset wins.
- done/err/ovf are held until the next accepted legal trigger or reset.

Test Plan:
- Reset then ADD: A=32'h0000_0005, B=32'h0000_0007, trig -> done_pulse exactly 2 cycles later, result=12, ovf=0, cmd_count=1, busy high for 2 cycles.
- SUB borrow and ADD carry:
  - SUB A=3, B=5 -> result=32'hFFFF_FFFE, ovf=1.
  - ADD 32'hFFFF_FFFF+1 -> result=0, ovf=1.
- MUL:
  - A=32'h0001_0000, B=32'h0001_0000 -> done_pulse at 34 cycles, result=0, ovf=1.
  - A=1234, B=5678 -> result=7006652, ovf=0.
- ACC sequence: CLR, then ACC A=10 three times -> result=30, cmd_count=4. With ACC_SATURATE=1, result=32'hFFFF_FFF0 then ACC A=32'h20 -> result=32'hFFFF_FFFF, ovf=1.
- Trigger during MUL at cycle 10 with op=ADD:
  - MUL result is unaffected and err=1 after completion.
  - The next legal trigger clears err.
  - Illegal op 7 from IDLE -> err=1, result unchanged, cmd_count unchanged.
- rst_n low at MULT iteration 20 -> next cycle all outputs 0, no done_pulse. A fresh ADD afterwards completes normally with cmd_count=1.
